// File: rtl/sopc_shared_mem_if.sv
// Requester-side bus of the shared memory: one read-only fetch port and one
// byte-enabled load/store data port.
interface sopc_shared_mem_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned SEL_W = DATA_W / 8;

    logic              if_ce_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic [DATA_W-1:0] if_data_o;
    logic              if_valid_o;
    logic              if_stall_o;

    logic              mem_ce_i;
    logic              mem_we_i;
    logic [SEL_W-1:0]  mem_sel_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [DATA_W-1:0] mem_data_i;
    logic [DATA_W-1:0] mem_data_o;
    logic              mem_valid_o;
    logic              mem_stall_o;

    modport slave (
        input  if_ce_i, if_addr_i,
        input  mem_ce_i, mem_we_i, mem_sel_i, mem_addr_i, mem_data_i,
        output if_data_o, if_valid_o, if_stall_o,
        output mem_data_o, mem_valid_o, mem_stall_o
    );

    modport master (
        output if_ce_i, if_addr_i,
        output mem_ce_i, mem_we_i, mem_sel_i, mem_addr_i, mem_data_i,
        input  if_data_o, if_valid_o, if_stall_o,
        input  mem_data_o, mem_valid_o, mem_stall_o
    );
endinterface

// File: rtl/sopc_shared_mem.sv
// Single-ported word memory shared by the instruction-fetch and data ports,
// with programmable wait states, arbitration and per-port stall signals.
module sopc_shared_mem #(
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned DEPTH_LOG2    = 10,
    parameter int unsigned WAIT_CYCLES   = 1,
    parameter int unsigned DATA_PRIORITY = 1
) (
    input logic              clk,
    input logic              rst,
    sopc_shared_mem_if.slave bus
);
    localparam int unsigned SEL_W = DATA_W / 8;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  owner_q, owner_d;        // 1 = data port owns the access
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic                  we_q, we_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic                  last_data_q, last_data_d;
    logic [DATA_W-1:0]     if_data_q, if_data_d;
    logic [DATA_W-1:0]     mem_data_q, mem_data_d;
    logic                  if_valid_q, if_valid_d;
    logic                  mem_valid_q, mem_valid_d;

    logic [DATA_W-1:0]     mem_q [DEPTH];

    logic                  if_elig_c;
    logic                  mem_elig_c;
    logic                  grant_data_c;
    logic                  wr_en_c;
    logic [DATA_W-1:0]     rd_word_c;
    logic [DATA_W-1:0]     wr_word_c;
    logic                  unused_addr_bits;

    // Only the word-index bits of either address reach the array.
    assign unused_addr_bits = ^{bus.if_addr_i, bus.mem_addr_i};

    assign if_elig_c    = bus.if_ce_i & ~if_valid_q;
    assign mem_elig_c   = bus.mem_ce_i & ~mem_valid_q;
    assign grant_data_c = mem_elig_c & (~if_elig_c | (DATA_PRIORITY != 0) | ~last_data_q);

    assign rd_word_c = mem_q[idx_q];

    // Byte merge: unselected lanes write back what is already stored.
    for (genvar b = 0; b < SEL_W; b++) begin : g_merge
        assign wr_word_c[8*b +: 8] = sel_q[b] ? wdata_q[8*b +: 8] : rd_word_c[8*b +: 8];
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        idx_d       = idx_q;
        we_d        = we_q;
        sel_d       = sel_q;
        wdata_d     = wdata_q;
        last_data_d = last_data_q;
        if_data_d   = if_data_q;
        mem_data_d  = mem_data_q;
        if_valid_d  = 1'b0;
        mem_valid_d = 1'b0;
        wr_en_c     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (if_elig_c | mem_elig_c) begin
                    owner_d     = grant_data_c;
                    idx_d       = grant_data_c ? bus.mem_addr_i[DEPTH_LOG2+1:2]
                                               : bus.if_addr_i[DEPTH_LOG2+1:2];
                    we_d        = grant_data_c & bus.mem_we_i;
                    sel_d       = bus.mem_sel_i;
                    wdata_d     = bus.mem_data_i;
                    cnt_d       = CNT_W'(WAIT_CYCLES);
                    last_data_d = grant_data_c;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = S_DONE;
                    if (owner_q) begin
                        mem_valid_d = 1'b1;
                        if (we_q) begin
                            wr_en_c = 1'b1;
                        end else begin
                            mem_data_d = rd_word_c;
                        end
                    end else begin
                        if_valid_d = 1'b1;
                        if_data_d  = rd_word_c;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            owner_q     <= 1'b0;
            idx_q       <= '0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            wdata_q     <= '0;
            last_data_q <= 1'b0;
            if_data_q   <= '0;
            mem_data_q  <= '0;
            if_valid_q  <= 1'b0;
            mem_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            idx_q       <= idx_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            wdata_q     <= wdata_d;
            last_data_q <= last_data_d;
            if_data_q   <= if_data_d;
            mem_data_q  <= mem_data_d;
            if_valid_q  <= if_valid_d;
            mem_valid_q <= mem_valid_d;
        end
    end

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem_q[idx_q] <= wr_word_c;
        end
    end

    assign bus.if_data_o   = if_data_q;
    assign bus.if_valid_o  = if_valid_q;
    assign bus.if_stall_o  = bus.if_ce_i & ~if_valid_q;
    assign bus.mem_data_o  = mem_data_q;
    assign bus.mem_valid_o = mem_valid_q;
    assign bus.mem_stall_o = bus.mem_ce_i & ~mem_valid_q;
endmodule

// File: tb/tb_sopc_shared_mem.sv
// Bench for sopc_shared_mem: two instances (fixed data priority, wait 1 and
// round-robin, wait 0) driven by the same directed stimulus.
module tb_sopc_shared_mem;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned DL = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_ce = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic        mem_ce = 1'b0;
    logic        mem_we = 1'b0;
    logic [3:0]  mem_sel = 4'h0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] mem_wdata = 32'h0;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    sopc_shared_mem_if #(.ADDR_W(AW), .DATA_W(DW)) bus_p ();
    sopc_shared_mem_if #(.ADDR_W(AW), .DATA_W(DW)) bus_r ();

    assign bus_p.if_ce_i    = if_ce;
    assign bus_p.if_addr_i  = if_addr;
    assign bus_p.mem_ce_i   = mem_ce;
    assign bus_p.mem_we_i   = mem_we;
    assign bus_p.mem_sel_i  = mem_sel;
    assign bus_p.mem_addr_i = mem_addr;
    assign bus_p.mem_data_i = mem_wdata;
    assign bus_r.if_ce_i    = if_ce;
    assign bus_r.if_addr_i  = if_addr;
    assign bus_r.mem_ce_i   = mem_ce;
    assign bus_r.mem_we_i   = mem_we;
    assign bus_r.mem_sel_i  = mem_sel;
    assign bus_r.mem_addr_i = mem_addr;
    assign bus_r.mem_data_i = mem_wdata;

    sopc_shared_mem #(.ADDR_W(AW), .DATA_W(DW), .DEPTH_LOG2(DL),
                      .WAIT_CYCLES(1), .DATA_PRIORITY(1)) dut_p (
        .clk(clk), .rst(rst), .bus(bus_p));

    sopc_shared_mem #(.ADDR_W(AW), .DATA_W(DW), .DEPTH_LOG2(DL),
                      .WAIT_CYCLES(0), .DATA_PRIORITY(0)) dut_r (
        .clk(clk), .rst(rst), .bus(bus_r));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Transaction-level model: one pending access per instance, timed by the
    // edge at which it reaches the array.
    int          wc[2]   = '{1, 0};
    bit          prio[2] = '{1'b1, 1'b0};
    logic [31:0] m_mem [2][16];
    logic [31:0] e_if_data[2], e_mem_data[2];
    bit          e_if_valid[2], e_mem_valid[2];
    bit          t_active[2], t_data[2], t_we[2], t_done[2], last_data[2];
    logic [3:0]  t_sel[2];
    logic [31:0] t_wd[2];
    int          t_idx[2], acc_at[2];
    int          edge_n = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                e_if_data[k] = 32'h0; e_mem_data[k] = 32'h0;
                e_if_valid[k] = 1'b0; e_mem_valid[k] = 1'b0;
                t_active[k] = 1'b0; t_done[k] = 1'b0; last_data[k] = 1'b0;
            end
        end else begin
            edge_n++;
            for (int k = 0; k < 2; k++) begin
                if (t_done[k]) begin
                    e_if_valid[k] = 1'b0; e_mem_valid[k] = 1'b0; t_done[k] = 1'b0;
                end else if (t_active[k]) begin
                    if (edge_n == acc_at[k]) begin
                        t_active[k] = 1'b0; t_done[k] = 1'b1;
                        if (t_data[k]) begin
                            e_mem_valid[k] = 1'b1;
                            if (t_we[k]) begin
                                for (int b = 0; b < 4; b++)
                                    if (t_sel[k][b]) m_mem[k][t_idx[k]][8*b +: 8] = t_wd[k][8*b +: 8];
                            end else begin
                                e_mem_data[k] = m_mem[k][t_idx[k]];
                            end
                        end else begin
                            e_if_valid[k] = 1'b1;
                            e_if_data[k]  = m_mem[k][t_idx[k]];
                        end
                    end
                end else if ((if_ce && !e_if_valid[k]) || (mem_ce && !e_mem_valid[k])) begin
                    t_data[k] = (mem_ce && !e_mem_valid[k]) &&
                                (!(if_ce && !e_if_valid[k]) || prio[k] || !last_data[k]);
                    t_idx[k]  = int'(((t_data[k] ? mem_addr : if_addr) >> 2) & 32'hF);
                    t_we[k]   = t_data[k] && mem_we;
                    t_sel[k]  = mem_sel;
                    t_wd[k]   = mem_wdata;
                    acc_at[k] = edge_n + wc[k] + 1;
                    t_active[k]  = 1'b1;
                    last_data[k] = t_data[k];
                end
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        check("p.if_data",   bus_p.if_data_o,   e_if_data[0]);
        check("p.mem_data",  bus_p.mem_data_o,  e_mem_data[0]);
        check("p.if_valid",  32'(bus_p.if_valid_o),  32'(e_if_valid[0]));
        check("p.mem_valid", 32'(bus_p.mem_valid_o), 32'(e_mem_valid[0]));
        check("p.if_stall",  32'(bus_p.if_stall_o),  32'(if_ce & ~e_if_valid[0]));
        check("p.mem_stall", 32'(bus_p.mem_stall_o), 32'(mem_ce & ~e_mem_valid[0]));
        check("r.if_data",   bus_r.if_data_o,   e_if_data[1]);
        check("r.mem_data",  bus_r.mem_data_o,  e_mem_data[1]);
        check("r.if_valid",  32'(bus_r.if_valid_o),  32'(e_if_valid[1]));
        check("r.mem_valid", 32'(bus_r.mem_valid_o), 32'(e_mem_valid[1]));
        check("r.if_stall",  32'(bus_r.if_stall_o),  32'(if_ce & ~e_if_valid[1]));
        check("r.mem_stall", 32'(bus_r.mem_stall_o), 32'(mem_ce & ~e_mem_valid[1]));
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    // Data access on the shared stimulus; returns latency and data seen on dut_p.
    task automatic mem_access(input bit we, input logic [3:0] sel, input logic [31:0] addr,
                              input logic [31:0] wd, output int lat, output logic [31:0] rd);
        bit got = 1'b0;
        mem_ce = 1'b1; mem_we = we; mem_sel = sel; mem_addr = addr; mem_wdata = wd;
        lat = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); lat++;
            @(negedge clk);
            if (bus_p.mem_valid_o) begin got = 1'b1; break; end
        end
        check("mem_done", 32'(got), 32'd1);
        rd = bus_p.mem_data_o;
        @(posedge clk); #2;
        mem_ce = 1'b0; mem_we = 1'b0;
        idle(4);
    endtask

    task automatic fetch(input logic [31:0] addr, output logic [31:0] rd);
        bit got = 1'b0;
        if_ce = 1'b1; if_addr = addr;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus_p.if_valid_o) begin got = 1'b1; break; end
        end
        check("fetch_done", 32'(got), 32'd1);
        rd = bus_p.if_data_o;
        @(posedge clk); #2;
        if_ce = 1'b0;
        idle(4);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, stall_cnt, p_if_cnt;
        logic [31:0] rd;
        bit          drop, got_if, mem_first;
        int          rr_q[$];
        int          exp_rr[4] = '{1, 0, 1, 0};

        repeat (2) @(negedge clk);
        check("rst.if_data",   bus_p.if_data_o,  32'h0);
        check("rst.mem_data",  bus_p.mem_data_o, 32'h0);
        check("rst.if_valid",  32'(bus_p.if_valid_o),  32'd0);
        check("rst.mem_valid", 32'(bus_p.mem_valid_o), 32'd0);
        @(posedge clk); #2;
        rst = 1'b1;
        idle(2);

        mem_access(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, lat, rd);
        check("wr_latency", 32'(lat), 32'd3);
        mem_access(1'b0, 4'hF, 32'h10, 32'h0, lat, rd);
        check("rd_latency", 32'(lat), 32'd3);
        check("rd_0x10", rd, 32'hDEADBEEF);

        mem_access(1'b1, 4'h1, 32'h10, 32'h000000AA, lat, rd);
        mem_access(1'b0, 4'hF, 32'h10, 32'h0, lat, rd);
        check("byte_en", rd, 32'hDEADBEAA);
        mem_access(1'b1, 4'h0, 32'h10, 32'hFFFFFFFF, lat, rd);
        check("sel0_latency", 32'(lat), 32'd3);
        mem_access(1'b0, 4'hF, 32'h10, 32'h0, lat, rd);
        check("sel0_nochange", rd, 32'hDEADBEAA);

        mem_access(1'b1, 4'hF, 32'h00, 32'h12345678, lat, rd);
        fetch(32'h40, rd);
        check("alias_0x40", rd, 32'h12345678);
        fetch(32'h03, rd);
        check("alias_0x03", rd, 32'h12345678);

        // Conflict on the fixed-priority instance: data first, then fetch.
        if_ce = 1'b1; if_addr = 32'h0;
        mem_ce = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h10;
        drop = 1'b0; got_if = 1'b0; mem_first = 1'b0; stall_cnt = 0;
        for (int i = 0; i < 40 && !got_if; i++) begin
            @(negedge clk);
            if (bus_p.mem_valid_o) begin drop = 1'b1; mem_first = !got_if; end
            if (bus_p.if_valid_o) got_if = 1'b1;
            else if (bus_p.if_stall_o) stall_cnt++;
            @(posedge clk); #2;
            if (drop) begin mem_ce = 1'b0; end
        end
        check("conf_if_done",   32'(got_if), 32'd1);
        check("conf_mem_first", 32'(mem_first), 32'd1);
        check("conf_stall_len", 32'(stall_cnt), 32'd7);
        check("conf_if_data",   bus_p.if_data_o,  32'h12345678);
        check("conf_mem_data",  bus_p.mem_data_o, 32'hDEADBEAA);
        if_ce = 1'b0; mem_ce = 1'b0;
        idle(4);

        // Reset in the wait state of a write: the old word must survive.
        mem_access(1'b1, 4'hF, 32'h20, 32'h0BADF00D, lat, rd);
        mem_ce = 1'b1; mem_we = 1'b1; mem_sel = 4'hF; mem_addr = 32'h20; mem_wdata = 32'hFFFFFFFF;
        @(posedge clk); #2;
        rst = 1'b0; mem_ce = 1'b0; mem_we = 1'b0;
        @(negedge clk);
        check("mrst.if_data",   bus_p.if_data_o,  32'h0);
        check("mrst.mem_data",  bus_p.mem_data_o, 32'h0);
        check("mrst.mem_valid", 32'(bus_p.mem_valid_o), 32'd0);
        idle(2);
        rst = 1'b1;
        idle(2);

        // Both ports requesting continuously right after reset.
        if_ce = 1'b1; if_addr = 32'h0;
        mem_ce = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h10;
        p_if_cnt = 0;
        repeat (16) begin
            @(negedge clk);
            if (bus_r.mem_valid_o) rr_q.push_back(1);
            if (bus_r.if_valid_o)  rr_q.push_back(0);
            if (bus_p.if_valid_o)  p_if_cnt++;
            @(posedge clk); #2;
        end
        if_ce = 1'b0; mem_ce = 1'b0;
        check("rr_count_min", 32'(rr_q.size() >= 4), 32'd1);
        for (int i = 0; i < 4; i++)
            check($sformatf("rr_grant%0d", i), (i < rr_q.size()) ? 32'(rr_q[i]) : 32'd2,
                  32'(exp_rr[i]));
        check("prio_starves_fetch", 32'(p_if_cnt), 32'd0);
        idle(6);

        fetch(32'h20, rd);
        check("rst_kept_0x20", rd, 32'h0BADF00D);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
